// File: rtl/log_afpm_pkg.sv
// Shared types and constants for the byte-serial floating-point multiplier.
// The NaN/Inf builders return 64-bit words; callers slice them to the operand width.
package log_afpm_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        CALC    = 2'd1,
        EMIT    = 2'd2
    } state_t;

    localparam int FLAGS_W   = 4;
    localparam int FLAG_ZERO = 0;
    localparam int FLAG_UNF  = 1;
    localparam int FLAG_OVF  = 2;
    localparam int FLAG_INV  = 3;

    // Positive infinity: exponent all-ones, mantissa zero, sign clear.
    function automatic logic [63:0] inf_val(input int exp_w, input int man_w);
        return ((64'd1 << exp_w) - 64'd1) << man_w;
    endfunction

    // Canonical quiet NaN: infinity pattern with the mantissa MSB set.
    function automatic logic [63:0] nan_val(input int exp_w, input int man_w);
        return inf_val(exp_w, man_w) | (64'd1 << (man_w - 1));
    endfunction

endpackage

// File: rtl/log_afpm_serial_if.sv
// Operand/result handshake bundle between the pad bus side and the multiplier.
// master drives operands and result-ready; slave is the multiplier.
interface log_afpm_serial_if #(
    parameter int BUS_W = 8
);
    import log_afpm_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [BUS_W-1:0]   in_a;
    logic [BUS_W-1:0]   in_b;
    logic               mode;
    logic               out_valid;
    logic               out_ready;
    logic [BUS_W-1:0]   out_data;
    logic [FLAGS_W-1:0] out_flags;

    modport master (
        output in_valid, in_a, in_b, mode, out_ready,
        input  in_ready, out_valid, out_data, out_flags
    );

    modport slave (
        input  in_valid, in_a, in_b, mode, out_ready,
        output in_ready, out_valid, out_data, out_flags
    );

endinterface

// File: rtl/log_afpm_core.sv
// Combinational multiply datapath: field decode, Mitchell and exact mantissa
// paths, exponent adjust and special-value resolution with status flags.
module log_afpm_core
    import log_afpm_pkg::*;
#(
    parameter  int EXP_W = 5,
    parameter  int MAN_W = 10,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic [W-1:0]       a,
    input  logic [W-1:0]       b,
    input  logic               mode,
    output logic [W-1:0]       result,
    output logic [FLAGS_W-1:0] flags
);

    localparam int                      EW2    = EXP_W + 2;
    localparam logic signed [EW2-1:0]   BIAS   = EW2'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW2-1:0]   EMAX   = EW2'((1 << EXP_W) - 1);
    localparam logic signed [EW2-1:0]   E_ZERO = '0;
    localparam logic [EXP_W-1:0]        EONES  = '1;
    localparam logic [63:0]             INF64  = inf_val(EXP_W, MAN_W);
    localparam logic [63:0]             NAN64  = nan_val(EXP_W, MAN_W);
    localparam logic [W-1:0]            INF_W  = INF64[W-1:0];
    localparam logic [W-1:0]            NAN_W  = NAN64[W-1:0];

    logic                   sa, sb, s;
    logic [EXP_W-1:0]       ea, eb;
    logic [MAN_W-1:0]       ma, mb, mout;
    logic                   a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [MAN_W:0]         msum;
    logic [2*MAN_W+1:0]     prod;
    logic                   c;
    logic signed [EW2-1:0]  e;
    logic [1:0]             e_rng;

    // {overflow, underflow} classification of the adjusted biased exponent.
    function automatic logic [1:0] exp_range(input logic signed [EW2-1:0] ev);
        return {ev >= EMAX, ev <= E_ZERO};
    endfunction

    assign {sa, ea, ma} = a;
    assign {sb, eb, mb} = b;
    assign s = sa ^ sb;

    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == EONES) && (ma == '0);
    assign b_inf  = (eb == EONES) && (mb == '0);
    assign a_nan  = (ea == EONES) && (ma != '0);
    assign b_nan  = (eb == EONES) && (mb != '0);

    assign msum = {1'b0, ma} + {1'b0, mb};
    assign prod = {{(MAN_W+1){1'b0}}, 1'b1, ma} * {{(MAN_W+1){1'b0}}, 1'b1, mb};

    // Carry means the mantissa sum/product reached [2,4): bump the exponent.
    always_comb begin
        if (mode) begin
            c    = prod[2*MAN_W+1];
            mout = c ? prod[2*MAN_W:MAN_W+1] : prod[2*MAN_W-1:MAN_W];
        end else begin
            c    = msum[MAN_W];
            mout = msum[MAN_W-1:0];
        end
    end

    assign e = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS
             + $signed({{(EXP_W+1){1'b0}}, c});
    assign e_rng = exp_range(e);

    always_comb begin
        result = {s, e[EXP_W-1:0], mout};
        flags  = '0;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            result          = NAN_W;
            flags[FLAG_INV] = 1'b1;
        end else if (a_inf || b_inf) begin
            result = {s, INF_W[W-2:0]};
        end else if (a_zero || b_zero) begin
            result           = {s, {(W-1){1'b0}}};
            flags[FLAG_ZERO] = 1'b1;
        end else if (e_rng[1]) begin
            result          = {s, INF_W[W-2:0]};
            flags[FLAG_OVF] = 1'b1;
        end else if (e_rng[0]) begin
            result           = {s, {(W-1){1'b0}}};
            flags[FLAG_UNF]  = 1'b1;
            flags[FLAG_ZERO] = 1'b1;
        end
    end

endmodule

// File: rtl/log_afpm_serial.sv
// Byte-serial floating-point multiplier: collects LS-first operand beats, computes
// one result with Mitchell or exact mantissa path, then streams it out LS-first.
module log_afpm_serial
    import log_afpm_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int BUS_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    log_afpm_serial_if.slave  bus
);

    localparam int              W      = 1 + EXP_W + MAN_W;
    localparam int              NBYTES = (W + BUS_W - 1) / BUS_W;
    localparam int              CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(NBYTES - 1);

    state_t                          state, state_n;
    logic [CNT_W-1:0]                cnt, cnt_n;
    logic                            in_fire;

    logic [NBYTES-1:0][BUS_W-1:0]    opa_p0, opb_p0;
    logic                            mode_p0;
    logic [NBYTES-1:0][BUS_W-1:0]    res_p1;
    logic [FLAGS_W-1:0]              flags_p1;

    logic [NBYTES*BUS_W-1:0]         opa_flat, opb_flat, res_pad;
    logic [W-1:0]                    core_res;
    logic [FLAGS_W-1:0]              core_flags;

    assign opa_flat = opa_p0;
    assign opb_flat = opb_p0;

    log_afpm_core #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_core (
        .a      (opa_flat[W-1:0]),
        .b      (opb_flat[W-1:0]),
        .mode   (mode_p0),
        .result (core_res),
        .flags  (core_flags)
    );

    always_comb begin
        res_pad        = '0;
        res_pad[W-1:0] = core_res;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= COLLECT;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        in_fire       = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        bus.out_flags = '0;
        case (state)
            COLLECT: begin
                bus.in_ready = 1'b1;
                in_fire      = bus.in_valid;
                if (in_fire) begin
                    if (cnt == LAST) begin
                        state_n = CALC;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
            CALC: begin
                state_n = EMIT;
            end
            EMIT: begin
                bus.out_valid = 1'b1;
                bus.out_data  = res_p1[cnt];
                bus.out_flags = flags_p1;
                if (bus.out_ready) begin
                    if (cnt == LAST) begin
                        state_n = COLLECT;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_n = COLLECT;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa_p0   <= '0;
            opb_p0   <= '0;
            mode_p0  <= 1'b0;
            res_p1   <= '0;
            flags_p1 <= '0;
        end else begin
            // p0: operand beats land in their slot; mode is frozen by the first beat
            if (in_fire) begin
                opa_p0[cnt] <= bus.in_a;
                opb_p0[cnt] <= bus.in_b;
                if (cnt == '0) begin
                    mode_p0 <= bus.mode;
                end
            end
            // p1: result and flags captured once, then held for every output beat
            if (state == CALC) begin
                res_p1   <= res_pad;
                flags_p1 <= core_flags;
            end
        end
    end

endmodule

// File: tb/tb_log_afpm_serial.sv
// Scoreboard bench for log_afpm_serial: 16-bit and 32-bit instances, randomized
// operands checked against an arithmetic model of the multiply rules.
module tb_log_afpm_serial;

    typedef struct {
        logic [63:0] word;
        logic [3:0]  flags;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   hold  = 0;
    exp_t q16[$];
    exp_t q32[$];

    always #5 clk = ~clk;

    log_afpm_serial_if #(.BUS_W(8)) b16 ();
    log_afpm_serial_if #(.BUS_W(8)) b32 ();

    log_afpm_serial #(.EXP_W(5), .MAN_W(10), .BUS_W(8)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (b16)
    );

    log_afpm_serial #(.EXP_W(8), .MAN_W(23), .BUS_W(8)) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (b32)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    function automatic exp_t mk(input logic [63:0] w, input logic [3:0] f);
        exp_t e;
        e.word  = w;
        e.flags = f;
        return e;
    endfunction

    // Reference multiply from the field definitions, using plain integer arithmetic.
    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic m, input int ew, input int mw);
        longint emax, bias, one, ea, eb, ma, mb, sa, sb, s, e, p, mo, c;
        logic   za, zb, ia, ib, na, nb;
        exp_t   r;
        emax = (longint'(1) << ew) - 1;
        bias = (longint'(1) << (ew - 1)) - 1;
        one  = longint'(1) << mw;
        ea = longint'(a >> mw) & emax;
        eb = longint'(b >> mw) & emax;
        ma = longint'(a) & (one - 1);
        mb = longint'(b) & (one - 1);
        sa = longint'(a >> (ew + mw)) & 1;
        sb = longint'(b >> (ew + mw)) & 1;
        s  = sa ^ sb;
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == emax) && (ma == 0);
        ib = (eb == emax) && (mb == 0);
        na = (ea == emax) && (ma != 0);
        nb = (eb == emax) && (mb != 0);
        if (m) begin
            p = (one + ma) * (one + mb);
            if (p >= (longint'(1) << (2 * mw + 1))) begin
                c  = 1;
                mo = (p >> (mw + 1)) - one;
            end else begin
                c  = 0;
                mo = (p >> mw) - one;
            end
        end else begin
            p = ma + mb;
            c = (p >= one) ? 1 : 0;
            mo = (p >= one) ? p - one : p;
        end
        e = ea + eb - bias + c;
        if (na || nb || (ia && zb) || (ib && za))
            r = mk(64'((emax << mw) | (one >> 1)), 4'b1000);
        else if (ia || ib)
            r = mk(64'((s << (ew + mw)) | (emax << mw)), 4'b0000);
        else if (za || zb)
            r = mk(64'(s << (ew + mw)), 4'b0001);
        else if (e >= emax)
            r = mk(64'((s << (ew + mw)) | (emax << mw)), 4'b0100);
        else if (e <= 0)
            r = mk(64'(s << (ew + mw)), 4'b0011);
        else
            r = mk(64'((s << (ew + mw)) | (e << mw) | mo), 4'b0000);
        return r;
    endfunction

    function automatic logic [63:0] rnd_op(input int ew, input int mw);
        longint emax, e, m, s;
        emax = (longint'(1) << ew) - 1;
        case ($urandom_range(0, 9))
            0:       e = 0;
            1:       e = emax;
            2:       e = longint'($urandom_range(1, 4));
            3:       e = emax - longint'($urandom_range(1, 4));
            default: e = longint'($urandom_range(1, int'(emax) - 1));
        endcase
        m = ($urandom_range(0, 5) == 0) ? 0 : (longint'($urandom) & ((longint'(1) << mw) - 1));
        s = longint'($urandom_range(0, 1));
        return 64'((s << (ew + mw)) | (e << mw) | m);
    endfunction

    task automatic set_in(input int sel, input logic v, input logic [7:0] a8,
                          input logic [7:0] b8, input logic m);
        if (sel == 0) begin
            b16.in_valid = v; b16.in_a = a8; b16.in_b = b8; b16.mode = m;
        end else begin
            b32.in_valid = v; b32.in_a = a8; b32.in_b = b8; b32.mode = m;
        end
    endtask

    function automatic logic get_ir(input int sel);
        return (sel == 0) ? b16.in_ready : b32.in_ready;
    endfunction

    function automatic logic get_ov(input int sel);
        return (sel == 0) ? b16.out_valid : b32.out_valid;
    endfunction

    task automatic check_idle(input int sel);
        if (sel == 0) begin
            check("idle_in_ready",  64'(b16.in_ready),  64'd1);
            check("idle_out_valid", 64'(b16.out_valid), 64'd0);
            check("idle_out_data",  64'(b16.out_data),  64'd0);
            check("idle_out_flags", 64'(b16.out_flags), 64'd0);
        end else begin
            check("idle_in_ready",  64'(b32.in_ready),  64'd1);
            check("idle_out_valid", 64'(b32.out_valid), 64'd0);
            check("idle_out_data",  64'(b32.out_data),  64'd0);
            check("idle_out_flags", 64'(b32.out_flags), 64'd0);
        end
    endtask

    task automatic push(input int sel, input exp_t e);
        if (sel == 0) q16.push_back(e);
        else          q32.push_back(e);
    endtask

    // Present one beat and return after the edge on which it transferred.
    task automatic send_beat(input int sel, input logic [7:0] a8, input logic [7:0] b8, input logic m);
        int t;
        set_in(sel, 1'b1, a8, b8, m);
        t = 0;
        @(negedge clk);
        while (!get_ir(sel) && t < 500) begin
            t++;
            @(negedge clk);
        end
        if (t >= 500) fail_now("in_ready_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic send_op(input int sel, input logic [63:0] a, input logic [63:0] b,
                           input logic m, input exp_t e, input int hold_after);
        int nb;
        logic [7:0] ab, bb;
        nb = (sel == 0) ? 2 : 4;
        push(sel, e);
        for (int i = 0; i < nb; i++) begin
            while ($urandom_range(0, 3) == 0) begin
                set_in(sel, 1'b0, 8'h00, 8'h00, 1'b0);
                @(posedge clk);
                #1;
            end
            ab = a[i*8 +: 8];
            bb = b[i*8 +: 8];
            send_beat(sel, ab, bb, (i == 0) ? m : 1'($urandom));
        end
        // Junk beats offered while busy must be ignored.
        set_in(sel, 1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
        if (hold_after > 0) hold = hold_after;
        @(negedge clk);
        check("calc_in_ready",  64'(get_ir(sel)), 64'd0);
        check("calc_out_valid", 64'(get_ov(sel)), 64'd0);
        @(negedge clk);
        check("latency_out_valid", 64'(get_ov(sel)), 64'd1);
        @(posedge clk);
        #1;
        set_in(sel, 1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((q16.size() != 0 || q32.size() != 0) && t < 5000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 5000) fail_now("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic mon(input int sel);
        logic [63:0] word;
        logic [3:0]  fl0, pf, of;
        logic [7:0]  pd, od;
        logic        stalled, ov, ordy, ir;
        int          nb, nbytes;
        exp_t        e;
        nbytes = (sel == 0) ? 2 : 4;
        nb = 0; stalled = 1'b0; word = '0; fl0 = '0; pd = '0; pf = '0;
        forever begin
            @(negedge clk);
            if (sel == 0) begin
                ov = b16.out_valid; ordy = b16.out_ready; ir = b16.in_ready;
                od = b16.out_data;  of = b16.out_flags;
            end else begin
                ov = b32.out_valid; ordy = b32.out_ready; ir = b32.in_ready;
                od = b32.out_data;  of = b32.out_flags;
            end
            if (rst) begin
                nb = 0; stalled = 1'b0; word = '0;
                if (sel == 0) q16.delete();
                else          q32.delete();
            end else if (ov) begin
                check("busy_in_ready", 64'(ir), 64'd0);
                if (stalled) begin
                    check("stall_data",  64'(od), 64'(pd));
                    check("stall_flags", 64'(of), 64'(pf));
                end
                if (ordy) begin
                    word[nb*8 +: 8] = od;
                    if (nb == 0) fl0 = of;
                    else         check("flags_hold", 64'(of), 64'(fl0));
                    nb++;
                    stalled = 1'b0;
                    if (nb == nbytes) begin
                        if ((sel == 0 && q16.size() == 0) || (sel != 0 && q32.size() == 0)) begin
                            fail_now("unexpected_result");
                        end else begin
                            if (sel == 0) e = q16.pop_front();
                            else          e = q32.pop_front();
                            check("result_word",  word, e.word);
                            check("result_flags", 64'(fl0), 64'(e.flags));
                        end
                        nb = 0;
                        word = '0;
                    end
                end else begin
                    stalled = 1'b1;
                    pd = od;
                    pf = of;
                end
            end else begin
                stalled = 1'b0;
            end
        end
    endtask

    initial mon(0);
    initial mon(1);

    initial begin
        logic r;
        b16.out_ready = 1'b0;
        b32.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (hold > 0) begin
                r = 1'b0;
                hold--;
            end else begin
                r = ($urandom_range(0, 3) != 0);
            end
            b16.out_ready = r;
            b32.out_ready = r;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a, b;
        logic        m;
        set_in(0, 1'b0, 8'h00, 8'h00, 1'b0);
        set_in(1, 1'b0, 8'h00, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_idle(0);
        check_idle(1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        send_op(0, 64'h3E00, 64'h3E00, 1'b1, mk(64'h4080, 4'b0000), 0);
        send_op(0, 64'h3E00, 64'h3E00, 1'b0, mk(64'h4000, 4'b0000), 0);
        send_op(0, 64'h3C00, 64'h4000, 1'b0, mk(64'h4000, 4'b0000), 0);
        send_op(0, 64'h0000, 64'hC000, 1'b1, mk(64'h8000, 4'b0001), 0);
        send_op(0, 64'h7800, 64'h7800, 1'b1, mk(64'h7C00, 4'b0100), 0);
        send_op(0, 64'h0400, 64'h0400, 1'b0, mk(64'h0000, 4'b0011), 0);
        send_op(0, 64'h7C00, 64'h0000, 1'b1, mk(64'h7E00, 4'b1000), 0);
        send_op(0, 64'h3E00, 64'h4000, 1'b1, mk(64'h4200, 4'b0000), 7);

        repeat (150) begin
            a = rnd_op(5, 10);
            b = rnd_op(5, 10);
            m = 1'($urandom);
            send_op(0, a, b, m, model(a, b, m, 5, 10), ($urandom_range(0, 15) == 0) ? 7 : 0);
        end
        wait_drain();

        // Reset with one operand beat already taken.
        send_beat(0, 8'h00, 8'h3C, 1'b1);
        set_in(0, 1'b0, 8'h00, 8'h00, 1'b0);
        rst = 1'b1;
        #1;
        check_idle(0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_op(0, 64'h3C00, 64'h3C00, 1'($urandom), mk(64'h3C00, 4'b0000), 0);
        wait_drain();

        // Reset while a result is stalled in the output stream.
        send_op(0, 64'h3E00, 64'h3E00, 1'b1, mk(64'h4080, 4'b0000), 40);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_idle(0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        hold = 0;
        send_op(0, 64'h3C00, 64'h3C00, 1'($urandom), mk(64'h3C00, 4'b0000), 0);
        wait_drain();

        send_op(1, 64'h3FC00000, 64'h40000000, 1'b1, mk(64'h40400000, 4'b0000), 0);
        repeat (40) begin
            a = rnd_op(8, 23);
            b = rnd_op(8, 23);
            m = 1'($urandom);
            send_op(1, a, b, m, model(a, b, m, 8, 23), 0);
        end
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
